note_stream_source: RTL and testbench

Producer side of the note-sample interface consumed by the dynamics stage. It accepts one note at a time from the song sequencer and produces four outputs:
- a per-sample `generate_next_sample` strobe
- a one-cycle `new_sample_ready` pulse marking the start of each note
- the note's `note_duration`
- a 16-bit triangle-wave `sample` at the note's pitch

It also counts beats against the duration and reports `note_done` to the sequencer.

---
 rtl/note_pkg.sv | 36 +++
 rtl/note_stream_source_if.sv | 33 +++
 rtl/triangle_osc.sv | 54 +++++
 rtl/note_stream_source.sv | 129 ++++++++++++
 tb/tb_note_stream_source.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note-sample producer: pitch table, pitch decode, FSM states.
// Latency: n/a (package, pure combinational helper function).
// Backpressure: n/a.
package note_pkg;

    // Pitch code 0 is a rest: no phase advance and a silent (zero) sample.
    localparam logic [5:0] REST = 6'd0;

    // Phase increments for the lowest octave (A1 = 55 Hz upward, one entry per semitone).
    localparam logic [15:0] BASE_INC [12] = '{
        16'd75,  16'd79,  16'd84,  16'd89,  16'd94,  16'd100,
        16'd106, 16'd112, 16'd119, 16'd126, 16'd134, 16'd142
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        PLAYING = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Octave doubles the increment; semitone picks the base entry.
    function automatic logic [15:0] note_to_inc(input logic [5:0] note);
        logic [5:0] idx;
        logic [2:0] octave;
        logic [3:0] semi;
        if (note == REST) begin
            return 16'd0;
        end
        idx    = note - 6'd1;
        octave = 3'(idx / 6'd12);
        semi   = 4'(idx % 6'd12);
        return BASE_INC[semi] << octave;
    endfunction

endpackage

// File: rtl/note_stream_source_if.sv
// Bundle between the song sequencer / dynamics stage and the note-sample producer.
// Latency: n/a (wiring only).
// Backpressure: none; load requests outside IDLE are simply dropped by the producer.
//   play, load_new_note, note_in, duration_in : sequencer -> producer
//   busy, note_done                           : producer -> sequencer
//   note_duration, new_sample_ready,
//   generate_next_sample, sample              : producer -> dynamics stage
interface note_stream_source_if;
    logic        play;
    logic        load_new_note;
    logic [5:0]  note_in;
    logic [5:0]  duration_in;
    logic        busy;
    logic        note_done;
    logic [5:0]  note_duration;
    logic        new_sample_ready;
    logic        generate_next_sample;
    logic [15:0] sample;

    // Producer side.
    modport master (
        input  play, load_new_note, note_in, duration_in,
        output busy, note_done, note_duration, new_sample_ready,
               generate_next_sample, sample
    );

    // Sequencer / consumer side.
    modport slave (
        output play, load_new_note, note_in, duration_in,
        input  busy, note_done, note_duration, new_sample_ready,
               generate_next_sample, sample
    );
endinterface

// File: rtl/triangle_osc.sv
// Phase accumulator plus triangle map producing a 16-bit two's-complement sample.
// Latency: sample reflects the new phase one cycle after clear/step.
// Backpressure: none; step advances phase unconditionally.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the phase (note start)
//   step       : advance phase by inc
//   inc        : 16-bit phase increment
//   rest       : force sample to zero
//   sample     : registered triangle sample
module triangle_osc
    import note_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [15:0] inc,
    input  logic        rest,
    output logic [15:0] sample
);

    logic [15:0] phase;
    logic [15:0] phase_next;

    // Upper half of the cycle folds back down; the doubled fold is centred on zero.
    function automatic logic [15:0] tri_map(input logic [15:0] p);
        logic [14:0] t;
        t = p[15] ? ~p[14:0] : p[14:0];
        return {t, 1'b0} - 16'h8000;
    endfunction

    always_comb begin
        phase_next = phase;
        if (clear) begin
            phase_next = '0;
        end else if (step) begin
            phase_next = phase + inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= '0;
            sample <= '0;
        end else begin
            phase <= phase_next;
            // Sample only moves with the phase so a frozen note holds its last value.
            if (clear || step) begin
                sample <= rest ? 16'd0 : tri_map(phase_next);
            end
        end
    end

endmodule

// File: rtl/note_stream_source.sv
// Plays one note at a time: sample strobes, triangle samples at pitch, beat counting to note_done.
// Latency: START the cycle after load; first strobe SAMPLE_DIV clocks after START; sample 1 cycle after strobe.
// Backpressure: none; play low freezes timing, loads while busy are dropped (no queueing).
//   clk, reset : clock and synchronous active-high reset
//   ns         : note_stream_source_if.master (play/load/note/duration in; busy, note_done,
//                note_duration, new_sample_ready, generate_next_sample, sample out)
module note_stream_source
    import note_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1125,
    parameter int BEAT_SAMPLES = 12000
) (
    input  logic                 clk,
    input  logic                 reset,
    note_stream_source_if.master ns
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SW = (BEAT_SAMPLES > 1) ? $clog2(BEAT_SAMPLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(BEAT_SAMPLES - 1);

    state_t        state;
    logic [5:0]    note_q;
    logic [5:0]    beats;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [SW-1:0] samp_cnt;
    logic          running;
    logic          last_strobe;
    logic          osc_clear;
    logic [15:0]   osc_inc;
    logic          osc_rest;

    assign running = ((state == START) || (state == PLAYING)) && ns.play;

    // The strobe output is registered, so it is raised on the edge where the prescaler
    // is about to land on its terminal count; the strobe then coincides with that count.
    always_comb begin
        presc_next = presc;
        if (state == START) begin
            presc_next = '0;
        end else if ((state == PLAYING) && ns.play) begin
            presc_next = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        end
    end

    // The strobe that completes the final beat of the note.
    assign last_strobe = ns.generate_next_sample && (samp_cnt == SAMP_LAST) &&
                         ((beats + 6'd1) == ns.note_duration);

    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            note_q                  <= '0;
            beats                   <= '0;
            presc                   <= '0;
            samp_cnt                <= '0;
            ns.busy                 <= 1'b0;
            ns.note_done            <= 1'b0;
            ns.note_duration        <= '0;
            ns.new_sample_ready     <= 1'b0;
            ns.generate_next_sample <= 1'b0;
        end else begin
            ns.new_sample_ready     <= 1'b0;
            ns.note_done            <= 1'b0;
            presc                   <= presc_next;
            ns.generate_next_sample <= running && (presc_next == PRESC_LAST) && !last_strobe;

            case (state)
                IDLE: begin
                    if (ns.load_new_note && ns.play) begin
                        note_q           <= ns.note_in;
                        ns.note_duration <= ns.duration_in;
                        ns.busy          <= 1'b1;
                        if (ns.duration_in == 6'd0) begin
                            state        <= DONE;
                            ns.note_done <= 1'b1;
                        end else begin
                            state               <= START;
                            ns.new_sample_ready <= 1'b1;
                        end
                    end
                end
                START: begin
                    samp_cnt <= '0;
                    beats    <= '0;
                    state    <= PLAYING;
                end
                PLAYING: begin
                    if (ns.generate_next_sample) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_cnt <= '0;
                            beats    <= beats + 6'd1;
                            if (last_strobe) begin
                                state        <= DONE;
                                ns.note_done <= 1'b1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SW'(1);
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ns.busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign osc_clear = (state == START);
    assign osc_inc   = note_to_inc(note_q);
    assign osc_rest  = (note_q == REST);

    triangle_osc u_osc (
        .clk    (clk),
        .reset  (reset),
        .clear  (osc_clear),
        .step   (ns.generate_next_sample),
        .inc    (osc_inc),
        .rest   (osc_rest),
        .sample (ns.sample)
    );

endmodule

// File: tb/tb_note_stream_source.sv
// Directed plus randomized bench for note_stream_source with a small pitch/waveform model.
// Latency: n/a.
// Backpressure: n/a.
module tb_note_stream_source;

    localparam int DIV  = 4;
    localparam int BEAT = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   model_sample = 0;
    int   strobe_q[$];
    int   nsr_q[$];
    int   done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    note_stream_source_if bus ();

    note_stream_source #(.SAMPLE_DIV(DIV), .BEAT_SAMPLES(BEAT)) dut (
        .clk   (clk),
        .reset (reset),
        .ns    (bus)
    );

    // Event log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.generate_next_sample === 1'b1) strobe_q.push_back(cyc);
        if (bus.new_sample_ready === 1'b1)     nsr_q.push_back(cyc);
        if (bus.note_done === 1'b1)            done_q.push_back(cyc);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pitch model: 55 Hz at code 1, each octave doubles the step.
    function automatic int inc_model(input int n);
        int base [12];
        base = '{75, 79, 84, 89, 94, 100, 106, 112, 119, 126, 134, 142};
        if (n == 0) return 0;
        return base[(n - 1) % 12] << ((n - 1) / 12);
    endfunction

    // Triangle rising from -32768 at phase 0 to 32766 at mid-cycle, then falling back.
    function automatic int tri_model(input int p);
        int q;
        q = p % 65536;
        if (q < 32768) return 2 * q - 32768;
        return 2 * (65535 - q) - 32768;
    endfunction

    function automatic int smp;
        return int'($signed(bus.sample));
    endfunction

    task automatic run_note(input int note, input int dur, input bit freeze, input bit busy_load);
        int L, s0, n0, d0, n, held_s, held_c, bad, d_cyc;
        s0 = strobe_q.size();
        n0 = nsr_q.size();
        d0 = done_q.size();
        bus.note_in       = 6'(note);
        bus.duration_in   = 6'(dur);
        bus.play          = 1'b1;
        bus.load_new_note = 1'b1;
        L = cyc;
        tick;
        bus.load_new_note = 1'b0;
        check("busy_after_load", int'(bus.busy), 1);
        if (dur == 0) check("zero_dur_done_now", int'(bus.note_done), 1);
        else          check("nsr_after_load", int'(bus.new_sample_ready), 1);

        n = 0;
        while (bus.note_done !== 1'b1 && n < 2000) begin
            n++;
            if (freeze && n == 7) begin
                bus.play = 1'b0;
                tick;
                tick;
                held_s = smp();
                held_c = strobe_q.size();
                repeat (8) tick;
                check("freeze_sample_held", smp(), held_s);
                check("freeze_no_strobe", strobe_q.size(), held_c);
                bus.play = 1'b1;
            end
            if (busy_load && n == 9) begin
                bus.note_in       = 6'(note ^ 21);
                bus.duration_in   = 6'(dur + 1);
                bus.load_new_note = 1'b1;
            end
            if (busy_load && n == 10) bus.load_new_note = 1'b0;
            tick;
        end
        bus.load_new_note = 1'b0;
        check("done_within_bound", int'(n < 2000), 1);
        d_cyc = cyc;

        if (dur > 0) model_sample = (note == 0) ? 0 : tri_model(dur * BEAT * inc_model(note));

        check("note_done_pulse", int'(bus.note_done), 1);
        check("busy_in_done", int'(bus.busy), 1);
        check("strobe_count", strobe_q.size() - s0, dur * BEAT);
        check("nsr_count", nsr_q.size() - n0, (dur > 0) ? 1 : 0);
        check("note_duration", int'(bus.note_duration), dur);
        check("final_sample", smp(), model_sample);
        if (dur > 0) begin
            if (nsr_q.size() > n0) check("nsr_cycle", nsr_q[n0], L + 1);
            if (strobe_q.size() > s0) begin
                check("done_after_last_strobe", d_cyc, strobe_q[strobe_q.size() - 1] + 1);
                if (!freeze) begin
                    check("first_strobe_cycle", strobe_q[s0], L + 1 + DIV);
                    bad = 0;
                    for (int k = s0 + 1; k < strobe_q.size(); k++)
                        if (strobe_q[k] - strobe_q[k - 1] != DIV) bad++;
                    check("strobe_spacing_errors", bad, 0);
                end
            end
        end else begin
            check("zero_dur_done_cycle", d_cyc, L + 1);
        end
        tick;
        check("busy_fall_after_done", int'(bus.busy), 0);
        check("note_done_one_cycle", int'(bus.note_done), 0);
        check("done_count", done_q.size() - d0, 1);
    endtask

    initial begin
        int s0, d0, n;

        // Reset with a simultaneous load request.
        reset             = 1'b1;
        bus.play          = 1'b1;
        bus.load_new_note = 1'b1;
        bus.note_in       = 6'd5;
        bus.duration_in   = 6'd2;
        tick;
        tick;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_note_done", int'(bus.note_done), 0);
        check("rst_note_duration", int'(bus.note_duration), 0);
        check("rst_nsr", int'(bus.new_sample_ready), 0);
        check("rst_strobe", int'(bus.generate_next_sample), 0);
        check("rst_sample", smp(), 0);
        reset             = 1'b0;
        bus.load_new_note = 1'b0;
        tick;
        check("load_during_reset_ignored", int'(bus.busy), 0);
        check("nsr_after_reset_load", nsr_q.size(), 0);

        // Normal note: 6 strobes of 75 -> phase 450.
        run_note(1, 2, 1'b0, 1'b0);
        check("note1_sample", smp(), -31868);

        // One octave up: first strobe gives phase 150.
        s0 = strobe_q.size();
        bus.note_in       = 6'd13;
        bus.duration_in   = 6'd1;
        bus.load_new_note = 1'b1;
        tick;
        bus.load_new_note = 1'b0;
        n = 0;
        while (strobe_q.size() == s0 && n < 100) begin
            tick;
            n++;
        end
        check("oct_strobe_within_bound", int'(n < 100), 1);
        check("oct_first_sample", smp(), -32468);
        n = 0;
        while (bus.note_done !== 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("oct_done_within_bound", int'(n < 200), 1);
        check("oct_final_sample", smp(), tri_model(BEAT * inc_model(13)));
        tick;
        model_sample = tri_model(BEAT * inc_model(13));

        // Rest, zero-duration, freeze with busy load.
        run_note(0, 2, 1'b0, 1'b0);
        run_note(7, 0, 1'b0, 1'b0);
        run_note(1, 2, 1'b1, 1'b1);

        // Reset mid-note after three strobes.
        s0 = strobe_q.size();
        bus.note_in       = 6'd2;
        bus.duration_in   = 6'd2;
        bus.load_new_note = 1'b1;
        tick;
        bus.load_new_note = 1'b0;
        n = 0;
        while (strobe_q.size() - s0 < 3 && n < 200) begin
            tick;
            n++;
        end
        check("midreset_strobes_within_bound", int'(n < 200), 1);
        d0 = done_q.size();
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_sample = 0;
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_sample", smp(), 0);
        check("midreset_duration", int'(bus.note_duration), 0);
        check("midreset_strobe", int'(bus.generate_next_sample), 0);
        repeat (20) tick;
        check("midreset_no_done", done_q.size() - d0, 0);
        check("midreset_still_idle", int'(bus.busy), 0);
        run_note(3, 1, 1'b0, 1'b0);

        // Randomized notes against the model.
        for (int i = 0; i < 8; i++) begin
            run_note(int'($urandom_range(63)), int'($urandom_range(3)),
                     1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
